// File: rtl/imu_pkg.sv
// Shared types and constants for the accelerometer sampling sequencer.
// Holds the FSM state encoding, register addresses and the boot-time config table.
package imu_pkg;

   typedef enum logic [3:0] {
      S_BOOT,
      S_ID_REQ,
      S_ID_WAIT,
      S_ERROR,
      S_CFG_REQ,
      S_CFG_WAIT,
      S_IDLE,
      S_RD_REQ,
      S_RD_WAIT,
      S_PUBLISH
   } state_e;

   localparam logic [7:0] WHOAMI_ADDR  = 8'h0F;
   localparam logic [7:0] OUT_X_L_ADDR = 8'h28;
   localparam int         BOOT_CYCLES  = 16;
   localparam logic [2:0] LAST_BYTE    = 3'd5;

   // {addr, data}: CTRL_REG1 400 Hz XYZ on, then CTRL_REG4 BDU + high-res
   function automatic logic [15:0] cfg_entry(input logic idx);
      return idx ? 16'h2388 : 16'h2077;
   endfunction

endpackage

// File: rtl/imu_sampler.sv
// Sequencer in front of the byte SPI master: ID check, config writes,
// then periodic 6-byte bursts published as three signed 16-bit samples.
module imu_sampler
   import imu_pkg::*;
#(
   parameter int         SAMPLE_PERIOD = 100000,
   parameter int         RETRY_PERIOD  = 1000000,
   parameter logic [7:0] WHOAMI_VAL    = 8'h33
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        run,
   input  logic [7:0]  spi_rdata,
   input  logic        spi_done,
   output logic [7:0]  spi_addr,
   output logic [7:0]  spi_wdata,
   output logic        spi_read,
   output logic        spi_enable,
   output logic [15:0] accel_x,
   output logic [15:0] accel_y,
   output logic [15:0] accel_z,
   output logic        sample_valid,
   output logic        id_ok,
   output logic        id_err
);

   localparam int PW = $clog2(SAMPLE_PERIOD);
   localparam int RW = $clog2(RETRY_PERIOD);
   localparam logic [PW-1:0] P_LAST = PW'(SAMPLE_PERIOD - 1);
   localparam logic [PW-1:0] B_LAST = PW'(BOOT_CYCLES - 1);
   localparam logic [RW-1:0] R_LAST = RW'(RETRY_PERIOD - 1);

   state_e          state_q, state_d;
   logic [PW-1:0]   cnt_q, cnt_d;
   logic [RW-1:0]   retry_q, retry_d;
   logic [2:0]      idx_q, idx_d;
   logic [5:0][7:0] shadow_q, shadow_d;
   logic [7:0]      addr_q, addr_d;
   logic [7:0]      wdata_q, wdata_d;
   logic            read_q, read_d;
   logic            en_q, en_d;
   logic [15:0]     ax_q, ax_d;
   logic [15:0]     ay_q, ay_d;
   logic [15:0]     az_q, az_d;
   logic            valid_q, valid_d;
   logic            ok_q, ok_d;
   logic            err_q, err_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      retry_d  = retry_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      read_d   = read_q;
      en_d     = 1'b0;
      ax_d     = ax_q;
      ay_d     = ay_q;
      az_d     = az_q;
      valid_d  = 1'b0;
      ok_d     = ok_q;
      err_d    = err_q;

      // Burst spacing is measured start-to-start, so keep counting mid-burst
      if (state_q == S_IDLE || state_q == S_RD_REQ ||
          state_q == S_RD_WAIT || state_q == S_PUBLISH) begin
         if (cnt_q != P_LAST) cnt_d = cnt_q + PW'(1);
      end

      unique case (state_q)
         S_BOOT: begin
            cnt_d = cnt_q + PW'(1);
            if (cnt_q == B_LAST) begin
               cnt_d   = '0;
               state_d = S_ID_REQ;
            end
         end
         S_ID_REQ: begin
            en_d    = 1'b1;
            read_d  = 1'b1;
            addr_d  = WHOAMI_ADDR;
            wdata_d = '0;
            state_d = S_ID_WAIT;
         end
         S_ID_WAIT: begin
            if (spi_done) begin
               if (spi_rdata == WHOAMI_VAL) begin
                  ok_d    = 1'b1;
                  err_d   = 1'b0;
                  idx_d   = '0;
                  state_d = S_CFG_REQ;
               end else begin
                  err_d   = 1'b1;
                  retry_d = '0;
                  state_d = S_ERROR;
               end
            end
         end
         S_ERROR: begin
            retry_d = retry_q + RW'(1);
            if (retry_q == R_LAST) state_d = S_ID_REQ;
         end
         S_CFG_REQ: begin
            en_d              = 1'b1;
            read_d            = 1'b0;
            {addr_d, wdata_d} = cfg_entry(idx_q[0]);
            state_d           = S_CFG_WAIT;
         end
         S_CFG_WAIT: begin
            if (spi_done) begin
               if (idx_q[0]) begin
                  cnt_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = S_CFG_REQ;
               end
            end
         end
         S_IDLE: begin
            if (cnt_q == P_LAST && run) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = S_RD_REQ;
            end
         end
         S_RD_REQ: begin
            en_d    = 1'b1;
            read_d  = 1'b1;
            addr_d  = OUT_X_L_ADDR + {5'b0, idx_q};
            wdata_d = '0;
            state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (spi_done) begin
               shadow_d[idx_q] = spi_rdata;
               if (idx_q == LAST_BYTE) begin
                  state_d = S_PUBLISH;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = S_RD_REQ;
               end
            end
         end
         S_PUBLISH: begin
            ax_d    = {shadow_q[1], shadow_q[0]};
            ay_d    = {shadow_q[3], shadow_q[2]};
            az_d    = {shadow_q[5], shadow_q[4]};
            valid_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= S_BOOT;
         cnt_q    <= '0;
         retry_q  <= '0;
         idx_q    <= '0;
         shadow_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         read_q   <= 1'b0;
         en_q     <= 1'b0;
         ax_q     <= '0;
         ay_q     <= '0;
         az_q     <= '0;
         valid_q  <= 1'b0;
         ok_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         retry_q  <= retry_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         read_q   <= read_d;
         en_q     <= en_d;
         ax_q     <= ax_d;
         ay_q     <= ay_d;
         az_q     <= az_d;
         valid_q  <= valid_d;
         ok_q     <= ok_d;
         err_q    <= err_d;
      end
   end

   assign spi_addr     = addr_q;
   assign spi_wdata    = wdata_q;
   assign spi_read     = read_q;
   assign spi_enable   = en_q;
   assign accel_x      = ax_q;
   assign accel_y      = ay_q;
   assign accel_z      = az_q;
   assign sample_valid = valid_q;
   assign id_ok        = ok_q;
   assign id_err       = err_q;

endmodule

// File: tb/tb_imu_sampler.sv
// Scoreboard bench for imu_sampler with a behavioural SPI slave.
// Stimulus pushes expected transactions/samples; the negedge monitor pops and compares.
module tb_imu_sampler;

   localparam int SP = 256;
   localparam int RP = 40;

   typedef struct {
      logic [7:0] addr;
      logic       rd;
      logic [7:0] wd;
   } txn_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        run = 1'b1;
   logic [7:0]  spi_rdata = 8'h00;
   logic        spi_done = 1'b0;
   logic [7:0]  spi_addr;
   logic [7:0]  spi_wdata;
   logic        spi_read;
   logic        spi_enable;
   logic [15:0] accel_x;
   logic [15:0] accel_y;
   logic [15:0] accel_z;
   logic        sample_valid;
   logic        id_ok;
   logic        id_err;

   always #5 clk = ~clk;

   imu_sampler #(
      .SAMPLE_PERIOD(SP),
      .RETRY_PERIOD (RP),
      .WHOAMI_VAL   (8'h33)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .run         (run),
      .spi_rdata   (spi_rdata),
      .spi_done    (spi_done),
      .spi_addr    (spi_addr),
      .spi_wdata   (spi_wdata),
      .spi_read    (spi_read),
      .spi_enable  (spi_enable),
      .accel_x     (accel_x),
      .accel_y     (accel_y),
      .accel_z     (accel_z),
      .sample_valid(sample_valid),
      .id_ok       (id_ok),
      .id_err      (id_err)
   );

   int errs = 0;
   int checks = 0;
   int cyc = 0;

   txn_t        exp_txn[$];
   logic [47:0] exp_samp[$];
   logic [7:0]  who_q[$];
   logic [7:0]  regs[6];
   int          starts[$];

   int          busy = 0;
   logic [7:0]  cur_addr = 8'h00;
   logic        cur_rd = 1'b0;
   int          n_en = 0;
   int          n_valid = 0;
   int          done_cyc = -1;
   int          last_done = -10;
   int          id_en_cyc = -1;
   bit          id_bad = 1'b0;
   logic [47:0] last_pub = '0;
   int          spur_req = 0;
   int          spur_ack = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor first, then the slave updates its drive for the next cycle
   always @(negedge clk) begin
      txn_t        t;
      logic [47:0] e;
      logic [7:0]  rd;
      cyc++;
      if (!reset_n) begin
         busy      = 0;
         spi_done  = 1'b0;
         id_bad    = 1'b0;
         last_pub  = '0;
         id_en_cyc = -1;
      end else begin
         if (sample_valid) begin
            n_valid++;
            if (exp_samp.size() == 0) begin
               chk("unexpected_sample", 1, 0);
            end else begin
               e = exp_samp.pop_front();
               chk("sample", {accel_x, accel_y, accel_z}, e);
            end
            last_pub = {accel_x, accel_y, accel_z};
         end
         if (spi_enable) begin
            n_en++;
            chk("enable_while_busy", (busy != 0) || (cyc < last_done + 2), 0);
            chk("accel_stable", {accel_x, accel_y, accel_z}, last_pub);
            if (exp_txn.size() == 0) begin
               chk("unexpected_txn", {spi_addr, 7'b0, spi_read}, 0);
            end else begin
               t = exp_txn.pop_front();
               if (t.rd)
                  chk("txn_read", {spi_addr, 7'b0, spi_read}, {t.addr, 8'h01});
               else
                  chk("txn_write", {spi_addr, spi_read, spi_wdata},
                      {t.addr, 1'b0, t.wd});
            end
            if (spi_addr == 8'h0F && id_bad)
               chk("retry_gap", cyc - done_cyc, RP + 2);
            if (spi_addr == 8'h0F && id_en_cyc < 0) id_en_cyc = cyc;
            if (spi_addr == 8'h28) starts.push_back(cyc);
            cur_addr = spi_addr;
            cur_rd   = spi_read;
            busy     = 33;
         end
         spi_done = 1'b0;
         if (busy > 0) begin
            busy--;
            if (busy == 0) begin
               rd = 8'h00;
               if (cur_rd && cur_addr == 8'h0F) begin
                  rd       = (who_q.size() != 0) ? who_q.pop_front() : 8'h33;
                  id_bad   = (rd != 8'h33);
                  done_cyc = cyc;
               end else if (cur_rd && cur_addr >= 8'h28 && cur_addr <= 8'h2D) begin
                  rd = regs[cur_addr - 8'h28];
               end
               spi_rdata = rd;
               spi_done  = 1'b1;
               last_done = cyc;
            end
         end else if (spur_req != spur_ack) begin
            spur_ack  = spur_req;
            spi_rdata = 8'hAA;
            spi_done  = 1'b1;
         end
      end
   end

   task automatic push_boot(input int n_bad);
      for (int i = 0; i <= n_bad; i++) exp_txn.push_back('{8'h0F, 1'b1, 8'h00});
      exp_txn.push_back('{8'h20, 1'b0, 8'h77});
      exp_txn.push_back('{8'h23, 1'b0, 8'h88});
   endtask

   task automatic push_burst(input logic [47:0] samp);
      for (int i = 0; i < 6; i++) exp_txn.push_back('{8'(8'h28 + i), 1'b1, 8'h00});
      exp_samp.push_back(samp);
   endtask

   task automatic set_regs(input logic [7:0] b0, b1, b2, b3, b4, b5);
      regs[0] = b0; regs[1] = b1; regs[2] = b2;
      regs[3] = b3; regs[4] = b4; regs[5] = b5;
   endtask

   task automatic release_and_check_id(input string name);
      int c0;
      @(negedge clk);
      #1 reset_n = 1'b1;
      c0 = cyc;
      repeat (20) @(negedge clk);
      chk(name, id_en_cyc - c0, 17);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int c;
      int k;
      int vcnt;
      set_regs(8'h01, 8'h80, 8'hFF, 8'h7F, 8'h00, 8'h00);

      wait_cycles(4);
      chk("reset_outputs",
          {spi_addr, spi_wdata, spi_read, spi_enable, accel_x, accel_y,
           accel_z, sample_valid, id_ok, id_err}, '0);

      push_boot(0);
      push_burst(48'h8001_7FFF_0000);
      push_burst(48'h8001_7FFF_0000);
      release_and_check_id("boot_id_cycle");

      for (int i = 0; i < 200 && !id_ok; i++) @(negedge clk);
      chk("id_ok_after_match", {id_ok, id_err}, 2'b10);

      for (int i = 0; i < 2000 && n_valid < 2; i++) @(negedge clk);
      chk("two_samples_seen", n_valid, 2);
      chk("burst_spacing", starts[1] - starts[0], SP);

      // Pause sampling: no enables may appear while run is low
      #1 run = 1'b0;
      k = n_en;
      wait_cycles(400);
      chk("run_low_no_enable", n_en - k, 0);

      set_regs(8'h34, 8'h12, 8'hCD, 8'hAB, 8'h00, 8'h80);
      push_burst(48'h1234_ABCD_8000);
      @(negedge clk);
      #1 run = 1'b1;
      c = cyc;
      for (int i = 0; i < 10 && starts.size() < 3; i++) @(negedge clk);
      chk("run_rise_start", starts[starts.size() - 1] - c, 2);

      for (int i = 0; i < 400 && n_valid < 3; i++) @(negedge clk);
      chk("third_sample_seen", n_valid, 3);

      set_regs(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
      push_burst(48'h2211_4433_6655);
      #1 spur_req++;
      k = n_en;
      wait_cycles(6);
      chk("spur_accel", {accel_x, accel_y, accel_z}, 48'h1234_ABCD_8000);
      chk("spur_no_enable", n_en - k, 0);

      for (int i = 0; i < 400 && starts.size() < 4; i++) @(negedge clk);
      chk("spacing_after_spur", starts[3] - starts[2], SP);

      // Abort the burst partway through its third read
      k = n_en;
      for (int i = 0; i < 200 && n_en < k + 2; i++) @(negedge clk);
      chk("third_read_reached", n_en - k, 2);
      wait_cycles(5);
      #1 reset_n = 1'b0;
      vcnt = n_valid;
      exp_txn.delete();
      exp_samp.delete();
      @(negedge clk);
      chk("midburst_reset_outputs",
          {spi_addr, spi_wdata, spi_read, spi_enable, accel_x, accel_y,
           accel_z, sample_valid, id_ok, id_err}, '0);
      wait_cycles(2);

      who_q.push_back(8'h00);
      who_q.push_back(8'h00);
      push_boot(2);
      release_and_check_id("reboot_id_cycle");

      for (int i = 0; i < 100 && !id_err; i++) @(negedge clk);
      chk("id_err_after_mismatch", {id_ok, id_err}, 2'b01);

      for (int i = 0; i < 1000 && !id_ok; i++) @(negedge clk);
      chk("id_ok_after_retry", {id_ok, id_err}, 2'b10);

      for (int i = 0; i < 300 && (exp_txn.size() != 0 || busy != 0); i++)
         @(negedge clk);
      chk("config_after_retry", exp_txn.size(), 0);
      chk("no_sample_for_aborted", n_valid - vcnt, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
